// File: rtl/src_stream_mm2s_if.sv
// Source stream valid/ready bundle.
// master drives data toward the sink, slave returns ready.
interface src_stream_mm2s_if #(
  parameter int DW = 32
);
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_last;
  logic          src_ready;

  modport master (
    output src_valid,
    output src_data,
    output src_last,
    input  src_ready
  );

  modport slave (
    input  src_valid,
    input  src_data,
    input  src_last,
    output src_ready
  );
endinterface

// File: rtl/src_stream_mm2s.sv
// Memory-to-stream transmitter with a prefetch FIFO.
// Optional stall counter: define MM2S_STALL_CNT_EN.
module src_stream_mm2s #(
  parameter int DW    = 32,
  parameter int AW    = 12,
  parameter int LW    = 13,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
`ifdef MM2S_STALL_CNT_EN
  output logic [31:0]   stall_cnt,
`endif
  src_stream_mm2s_if.master src
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t        state;
  logic [DW-1:0] fifo_q [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          inflight;
  logic [AW-1:0] rd_addr;
  logic [LW-1:0] rd_left;
  logic [LW-1:0] wr_left;
  logic          issue;
  logic          push;
  logic          pop;

  assign push  = inflight;
  assign pop   = src.src_valid & src.src_ready;
  assign issue = (state == RUN)
               && (rd_left != '0)
               && ((count + CW'(inflight))
                   < CW'(DEPTH));

  assign mem_re        = issue;
  assign mem_addr      = rd_addr;
  assign src.src_valid = (count != '0);
  assign src.src_data  = fifo_q[rptr];
  assign src.src_last  = src.src_valid
                       && (wr_left == LW'(1));

  // Transfer control: accept start, issue reads, finish on last pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_addr <= '0;
      rd_left <= '0;
      wr_left <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              rd_addr <= base;
              rd_left <= len;
              wr_left <= len;
              busy    <= 1'b1;
              state   <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            rd_addr <= rd_addr + AW'(1);
            rd_left <= rd_left - LW'(1);
            if (rd_left == LW'(1)) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
        end
        default: state <= IDLE;
      endcase
      if ((state != IDLE) && pop) begin
        wr_left <= wr_left - LW'(1);
        if (src.src_last) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  // Prefetch FIFO: push read data one cycle after the read, pop on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (push) begin
        fifo_q[wptr] <= mem_rdata;
        wptr         <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifndef SYNTHESIS
  // A push never lands in a full FIFO; the read credit reserves the slot.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && (count == CW'(DEPTH))));
    end
  end
`endif

`ifdef MM2S_STALL_CNT_EN
  // Count busy cycles where data waits on the sink, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start
                 && (len != '0)) begin
      stall_cnt <= '0;
    end else if (busy && src.src_valid
                 && !src.src_ready
                 && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_src_stream_mm2s.sv
// Bench for src_stream_mm2s: queue model of the expected stream,
// checked every cycle, plus directed literal checks.
module tb_src_stream_mm2s;
  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int LW    = 13;
  localparam int DEPTH = 4;
  localparam int MSZ   = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [LW-1:0] len = '0;
  logic          busy;
  logic          done;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
`ifdef MM2S_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  src_stream_mm2s_if #(.DW(DW)) s ();

  src_stream_mm2s #(
    .DW(DW), .AW(AW), .LW(LW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base(base),
    .len(len),
    .busy(busy),
    .done(done),
    .mem_re(mem_re),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
`ifdef MM2S_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .src(s)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [MSZ];
  logic [DW-1:0] ofs = '0;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr] + ofs;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endfunction

  logic [DW-1:0] exp_q [$];
  int            addr_log [$];
  int            exp_addr = 0;
  int            reads_left = 0;
  int            reads_out = 0;
  int            n_reads = 0;
  int            n_hs = 0;
  int            done_cnt = 0;
  int            acc_cyc = 0;
  int            done_cyc = 0;
  int            fv_cyc = 0;
  bit            mbusy = 0;
  bit            done_next = 0;
  bit            fv_seen = 0;
  logic [DW-1:0] first_data = '0;
  logic [DW-1:0] last_data = '0;
  logic [31:0]   stall_m = '0;

  always @(negedge clk) begin
    bit was_busy;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_valid", s.src_valid, 0);
      chk("rst_last", s.src_last, 0);
      exp_q.delete();
      reads_left = 0;
      reads_out  = 0;
      mbusy      = 0;
      done_next  = 0;
      stall_m    = '0;
    end else begin
      was_busy = mbusy;
      chk("done", done, done_next);
      done_next = 0;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      chk("busy", busy, mbusy);
`ifdef MM2S_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, stall_m);
      if (mbusy && s.src_valid && !s.src_ready
          && stall_m != 32'hFFFF_FFFF)
        stall_m = stall_m + 32'd1;
`endif
      if (mem_re) begin
        chk("read_expected", reads_left > 0, 1);
        chk("mem_addr", mem_addr, exp_addr);
        chk("read_credit", reads_out < DEPTH, 1);
        addr_log.push_back(int'(mem_addr));
        exp_addr = (exp_addr + 1) % MSZ;
        reads_left--;
        reads_out++;
        n_reads++;
      end
      if (s.src_valid) begin
        if (!fv_seen) begin
          fv_seen    = 1;
          fv_cyc     = cyc;
          first_data = s.src_data;
        end
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          chk("src_data", s.src_data, exp_q[0]);
          chk("src_last", s.src_last,
              exp_q.size() == 1);
          if (s.src_ready) begin
            last_data = exp_q.pop_front();
            n_hs++;
            reads_out--;
            if (exp_q.size() == 0) begin
              mbusy     = 0;
              done_next = 1;
            end
          end
        end
      end else begin
        chk("last_no_valid", s.src_last, 0);
      end
      if (start && !was_busy) begin
        acc_cyc = cyc + 1;
        fv_seen = 0;
        n_reads = 0;
        n_hs    = 0;
        addr_log.delete();
        if (len == '0) begin
          done_next = 1;
        end else begin
          mbusy      = 1;
          exp_addr   = int'(base);
          reads_left = int'(len);
          reads_out  = 0;
          stall_m    = '0;
          for (int i = 0; i < int'(len); i++)
            exp_q.push_back(
              mem[(int'(base) + i) % MSZ] + ofs);
        end
      end
    end
  end

  int go_d0 = 0;

  task automatic go(input logic [AW-1:0] b,
                    input logic [LW-1:0] l);
    @(posedge clk); #1;
    go_d0 = done_cnt;
    start = 1'b1;
    base  = b;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm,
                           input int budget);
    int i;
    i = 0;
    while (done_cnt == go_d0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk(nm, done_cnt != go_d0, 1);
  endtask

  initial begin
    for (int a = 0; a < MSZ; a++)
      mem[a] = 32'hA000_0000 + DW'(a);
    s.src_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_src_data", s.src_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;

    // basic burst, sink always ready
    go(12'h010, 13'd5);
    wait_done("t1_done_seen", 30);
    chk("t1_first_lat", fv_cyc - acc_cyc, 2);
    chk("t1_done_lat", done_cyc - acc_cyc, 7);
    chk("t1_first_word", first_data, 32'hA000_0010);
    chk("t1_last_word", last_data, 32'hA000_0014);
    chk("t1_words", n_hs, 5);

    // zero length: done only
    go(12'h123, 13'd0);
    wait_done("t2_done_seen", 5);
    chk("t2_done_next", done_cyc, acc_cyc);
    chk("t2_reads", n_reads, 0);
    chk("t2_valid", fv_seen, 0);

    // address wrap
    go(12'hFFE, 13'd4);
    wait_done("t3_done_seen", 30);
    chk("t3_naddr", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("t3_addr0", addr_log[0], 12'hFFE);
      chk("t3_addr1", addr_log[1], 12'hFFF);
      chk("t3_addr2", addr_log[2], 12'h000);
      chk("t3_addr3", addr_log[3], 12'h001);
    end
    chk("t3_last_word", last_data, 32'hA000_0001);

    // long stall then release
    s.src_ready = 1'b0;
    go(12'h100, 13'd10);
    for (int i = 0; i < 20 && !s.src_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("t4_valid_seen", s.src_valid, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("t4_reads_stalled", n_reads, 4);
    chk("t4_data_held", s.src_data, 32'hA000_0100);
    s.src_ready = 1'b1;
    wait_done("t4_done_seen", 40);
    chk("t4_words", n_hs, 10);
    chk("t4_last_word", last_data, 32'hA000_0109);
`ifdef MM2S_STALL_CNT_EN
    chk("t4_stall_cnt", stall_cnt, 20);
`endif

    // toggling ready, with a start ignored mid-transfer
    go(12'h200, 13'd8);
    for (int i = 0; i < 60 && done_cnt == go_d0; i++) begin
      @(posedge clk); #1;
      s.src_ready = ~s.src_ready;
      start = (i == 2);
      base  = 12'h777;
      len   = 13'd3;
    end
    start = 1'b0;
    s.src_ready = 1'b1;
    chk("t5_done_seen", done_cnt != go_d0, 1);
    chk("t5_words", n_hs, 8);
    chk("t5_last_word", last_data, 32'hA000_0207);

    // reset mid-transfer, then a fresh short burst
    ofs = 32'h0500_0000;
    go(12'h300, 13'd10);
    for (int i = 0; i < 40 && n_hs < 3; i++)
      @(posedge clk);
    #1;
    chk("t6_hs_before_rst", n_hs, 3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", s.src_valid, 0);
    chk("t6_rst_mem_re", mem_re, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ofs = 32'h0600_0000;
    go(12'h040, 13'd2);
    wait_done("t6_done_seen", 20);
    chk("t6_words", n_hs, 2);
    chk("t6_first_word", first_data, 32'hA600_0040);
    chk("t6_last_word", last_data, 32'hA600_0041);
    chk("t6_done_lat", done_cyc - acc_cyc, 4);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/src_stream_mm2s.md
Name: src_stream_mm2s

Overview:
Memory-to-stream transmitter that drives the accelerator's source stream (src_valid/src_data/src_last, back-pressured by src_ready). On a start pulse it reads len consecutive words from a local SRAM-style memory, starting at base. It emits them in order as a valid/ready stream and asserts last on the final word. A small prefetch FIFO hides the one-cycle memory read latency, so the stream sustains one word per clock when the sink is always ready.

Parameters:
DW, 32, stream/memory data width
AW, 12, memory word-address width
LW, 13, transfer length width (up to 4096 words)
DEPTH, 4, prefetch FIFO depth (power of two, >=2)

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a transfer; ignored while busy
base  in  AW  first memory word address, sampled on accepted start
len  in  LW  number of words, sampled on accepted start; 0 = no-op
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when final word handshakes (or no-op completes)
mem_re  out  1  memory read enable
mem_addr  out  AW  memory read address
mem_rdata  in  DW  read data, valid exactly one cycle after mem_re
src_valid  out  1  stream data valid
src_data  out  DW  stream data
src_last  out  1  marks final word of transfer
src_ready  in  1  sink ready

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, mem_re, src_valid, src_last = 0; mem_addr, src_data = 0; FIFO empty; counters 0. Reset mid-transfer aborts it and discards all FIFO contents and in-flight reads.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - start with len!=0: latch base into rd_addr, len into rd_left and wr_left; go to RUN; busy=1 next cycle.
  - start with len==0: done=1 for one cycle; stay IDLE; busy stays 0.
- RUN:
  - Issue a read (mem_re=1, mem_addr=rd_addr) when rd_left!=0 and fifo_count + inflight < DEPTH. inflight is a 1-bit register equal to last cycle's mem_re.
  - Each issued read increments rd_addr (wraps modulo 2^AW) and decrements rd_left.
  - The cycle after mem_re, mem_rdata is pushed into the FIFO.
  - When rd_left reaches 0, go to FLUSH.
- FLUSH: no further reads; drain the FIFO.
- Stream output:
  - src_valid = FIFO non-empty; src_data = FIFO head.
  - src_last = src_valid and wr_left==1.
  - A handshake is src_valid & src_ready. It pops the FIFO and decrements wr_left.
  - Once asserted, src_valid and src_data hold stable until the handshake.
- Completion: handshake with src_last=1 gives done=1 the next cycle, busy=0, state IDLE.
- Simultaneous push and pop in one cycle: fifo_count is unchanged; the ordering is valid.
- The credit rule guarantees no FIFO overflow. A push into a full FIFO is impossible; add an assertion.
- Latency: with src_ready held 1, the first src_valid appears 2 cycles after start. Thereafter one word per cycle; len words take len+2 cycles up to done.
- start while busy: ignored, no effect on the transfer.
- With src_ready held 0, at most DEPTH reads are issued, then mem_re stays 0 until the sink pops.

Optional Feature:
Macro MM2S_STALL_CNT_EN.
- Defined: adds output stall_cnt (32 bits). It clears to 0 on each accepted start with len!=0 and increments every busy cycle where src_valid=1 and src_ready=0. It saturates at all-ones and holds its value after done until the next start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- base=0x010, len=5, memory[i]=0xA0000000+i, src_ready=1 -> src_data 0xA0000010..0xA0000014 on 5 consecutive cycles; src_last only on 0xA0000014; done 7 cycles after start.
- len=0 start -> done pulses 1 cycle later; busy, mem_re and src_valid never assert.
- base=0xFFE, len=4 -> mem_addr sequence 0xFFE, 0xFFF, 0x000, 0x001; data order preserved.
- len=10, src_ready=0 for 20 cycles then 1 -> exactly 4 reads issued while stalled; src_data stable; all 10 words delivered in order. With MM2S_STALL_CNT_EN, stall_cnt=20 at done.
- src_ready toggling 1,0,1,0 on len=8 -> 8 handshakes, no duplicates or drops, src_last on the 8th.
- rst_n=0 asserted mid-transfer (after 3 words) -> outputs 0 immediately. A new start with len=2 then delivers exactly 2 fresh words with correct last/done.
